// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, immediate-type encoding and the
// decoded entry carried through the decode pipeline register.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_NONE = 3'b101,
    IMM_ILL  = 3'b111
  } imm_sel_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    imm;
    imm_sel_e           imm_sel;
    logic               illegal;
  } dec_entry_t;

  // Map the major opcode onto the immediate format it uses.
  function automatic imm_sel_e decode_imm_sel(input logic [OPC_W-1:0] opc);
    imm_sel_e sel;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR,
      OPC_FENCE, OPC_SYSTEM:          sel = IMM_I;
      OPC_STORE:                      sel = IMM_S;
      OPC_BRANCH:                     sel = IMM_B;
      OPC_JAL:                        sel = IMM_J;
      OPC_LUI, OPC_AUIPC:             sel = IMM_U;
      OPC_OP:                         sel = IMM_NONE;
      default:                        sel = IMM_ILL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/immediate_generator.sv
// Combinational RV32 immediate extraction; formats without an immediate
// (register-register and illegal) produce zero.
module immediate_generator
  import riscv_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  imm_sel_e           imm_sel,
  output logic [XLEN-1:0]    imm_c
);

  always_comb begin
    imm_c = '0;
    case (imm_sel)
      IMM_I: imm_c = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_J: imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      IMM_U: imm_c = {instr[31:12], 12'b0};
      default: imm_c = '0;
    endcase
  end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode front end: classifies the fetched instruction, builds its immediate
// and holds it in a two-entry (output + skid) pipeline register.
module decode_imm_stage
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic [XLEN-1:0]        out_imm,
  output logic [2:0]             out_imm_sel,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  imm_sel_e         imm_sel_c;
  logic [XLEN-1:0]  imm_c;
  dec_entry_t       in_entry_c;

  dec_entry_t       out_q, skid_q, out_d_c;
  logic [PC_W-1:0]  out_pc_q, skid_pc_q, out_pc_d_c;
  logic             out_valid_q, skid_valid_q, in_ready_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic accept_c, out_free_c, out_load_c, skid_load_c;
  logic out_valid_n, skid_valid_n, stall_inc_c;

  assign imm_sel_c = decode_imm_sel(in_instr[6:0]);

  immediate_generator u_immgen (
    .instr   (in_instr),
    .imm_sel (imm_sel_c),
    .imm_c   (imm_c)
  );

  always_comb begin
    in_entry_c         = '0;
    in_entry_c.instr   = in_instr;
    in_entry_c.imm     = imm_c;
    in_entry_c.imm_sel = imm_sel_c;
    in_entry_c.illegal = (imm_sel_c == IMM_ILL);
  end

  assign accept_c   = in_valid & in_ready_q;
  assign out_free_c = ~out_valid_q | out_ready;

  // Skid entry is older than anything on the input, so it always drains first.
  assign out_d_c    = skid_valid_q ? skid_q    : in_entry_c;
  assign out_pc_d_c = skid_valid_q ? skid_pc_q : in_pc;

  // Occupancy sequencing for the output and skid slots.
  always_comb begin
    out_valid_n  = out_valid_q;
    skid_valid_n = skid_valid_q;
    out_load_c   = 1'b0;
    skid_load_c  = 1'b0;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (out_free_c) begin
      out_valid_n  = skid_valid_q | accept_c;
      out_load_c   = skid_valid_q | accept_c;
      skid_valid_n = skid_valid_q & accept_c;
      skid_load_c  = skid_valid_q & accept_c;
    end else if (accept_c) begin
      skid_valid_n = 1'b1;
      skid_load_c  = 1'b1;
    end
  end

  assign stall_inc_c = out_valid_q & ~out_ready & ~(&stall_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_pc_q     <= '0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      stall_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_n;
      skid_valid_q <= skid_valid_n;
      in_ready_q   <= ~skid_valid_n;
      if (out_load_c) begin
        out_q    <= out_d_c;
        out_pc_q <= out_pc_d_c;
      end
      if (skid_load_c) begin
        skid_q    <= in_entry_c;
        skid_pc_q <= in_pc;
      end
      if (stall_inc_c) begin
        stall_q <= stall_q + STALL_CNT_W'(1);
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_q.instr;
  assign out_pc      = out_pc_q;
  assign out_imm     = out_q.imm;
  assign out_imm_sel = out_q.imm_sel;
  assign out_illegal = out_q.illegal;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed bench for decode_imm_stage: decode of each format, skid
// backpressure ordering, flush, stall counter saturation and reset.
module tb_decode_imm_stage;

  localparam int unsigned PC_W = 32;
  localparam int unsigned SW   = 4;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic            in_ready, out_valid, out_illegal;
  logic [31:0]     in_instr, out_instr, out_imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [2:0]      out_imm_sel;
  logic [SW-1:0]   stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  decode_imm_stage #(.PC_W(PC_W), .STALL_CNT_W(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_imm_sel (out_imm_sel),
    .out_illegal (out_illegal),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr,
                         input logic [31:0] imm, input logic [2:0] sel,
                         input logic ill, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".instr"}, out_instr, instr);
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".sel"}, 32'(out_imm_sel), 32'(sel));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
    chk({tag, ".pc"}, out_pc, pc);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.imm", out_imm, 32'd0);
    chk("rst.instr", out_instr, 32'd0);
    chk("rst.stall", 32'(stall_count), 32'd0);
    rst = 1'b0;

    // Single I-type, then mixed formats back to back with a free sink
    out_ready = 1'b1;
    offer(32'hFFF00093, 32'h100); tick();
    chk_out("addi", 32'hFFF00093, 32'hFFFFFFFF, 3'b000, 1'b0, 32'h100);
    offer(32'h00112623, 32'h104); tick();
    chk_out("sw", 32'h00112623, 32'h0000000C, 3'b001, 1'b0, 32'h104);
    offer(32'hFE000EE3, 32'h108); tick();
    chk_out("beq", 32'hFE000EE3, 32'hFFFFFFFC, 3'b010, 1'b0, 32'h108);
    offer(32'h123452B7, 32'h10C); tick();
    chk_out("lui", 32'h123452B7, 32'h12345000, 3'b100, 1'b0, 32'h10C);
    offer(32'h0000007F, 32'h110); tick();
    chk_out("ill", 32'h0000007F, 32'h00000000, 3'b111, 1'b1, 32'h110);
    offer(32'h0080006F, 32'h114); tick();
    chk_out("jal", 32'h0080006F, 32'h00000008, 3'b011, 1'b0, 32'h114);
    offer(32'h002081B3, 32'h118); tick();
    chk_out("add", 32'h002081B3, 32'h00000000, 3'b101, 1'b0, 32'h118);
    offer(32'h00001097, 32'h11C); tick();
    chk_out("auipc", 32'h00001097, 32'h00001000, 3'b100, 1'b0, 32'h11C);
    in_valid = 1'b0; tick();
    chk("idle.valid", 32'(out_valid), 32'd0);
    chk("idle.stall", 32'(stall_count), 32'd0);

    // Backpressure: A in output, B in skid, C held off
    out_ready = 1'b0;
    offer(32'h00A00093, 32'h200); tick();
    chk_out("bpA", 32'h00A00093, 32'd10, 3'b000, 1'b0, 32'h200);
    chk("bp.ready0", 32'(in_ready), 32'd1);
    chk("bp.stall0", 32'(stall_count), 32'd0);
    offer(32'h01400113, 32'h204); tick();
    chk_out("bpA2", 32'h00A00093, 32'd10, 3'b000, 1'b0, 32'h200);
    chk("bp.ready1", 32'(in_ready), 32'd0);
    chk("bp.stall1", 32'(stall_count), 32'd1);
    offer(32'h01E00193, 32'h208); tick();
    chk("bp.ready2", 32'(in_ready), 32'd0);
    chk("bp.stall2", 32'(stall_count), 32'd2);
    tick();
    chk_out("bpA3", 32'h00A00093, 32'd10, 3'b000, 1'b0, 32'h200);
    chk("bp.stall3", 32'(stall_count), 32'd3);
    out_ready = 1'b1; tick();
    chk_out("bpB", 32'h01400113, 32'd20, 3'b000, 1'b0, 32'h204);
    chk("bp.ready4", 32'(in_ready), 32'd1);
    tick();
    chk_out("bpC", 32'h01E00193, 32'd30, 3'b000, 1'b0, 32'h208);
    in_valid = 1'b0; tick();
    chk("bp.drain", 32'(out_valid), 32'd0);
    chk("bp.stall", 32'(stall_count), 32'd3);

    // Flush with output full and a same-cycle accept
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    offer(32'h00100093, 32'h300); tick();
    flush = 1'b1;
    offer(32'h00200093, 32'h304); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1.valid", 32'(out_valid), 32'd0);
    chk("fl1.ready", 32'(in_ready), 32'd1);
    chk("fl1.stall", 32'(stall_count), 32'd1);
    tick();
    chk("fl1.drop", 32'(out_valid), 32'd0);

    // Flush with both entries full and fetch still presenting
    offer(32'h00300093, 32'h308); tick();
    offer(32'h00400093, 32'h30C); tick();
    chk("fl2.full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    offer(32'h00500093, 32'h310); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2.valid", 32'(out_valid), 32'd0);
    chk("fl2.ready", 32'(in_ready), 32'd1);
    chk("fl2.stall", 32'(stall_count), 32'd3);
    tick();
    chk("fl2.drop", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    offer(32'h00600093, 32'h314); tick();
    chk_out("fl2.next", 32'h00600093, 32'd6, 3'b000, 1'b0, 32'h314);

    // Saturation: hold the entry for 20 cycles
    out_ready = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat.stall", 32'(stall_count), 32'd15);
    chk("sat.valid", 32'(out_valid), 32'd1);

    // Reset with both entries full
    offer(32'h00700093, 32'h318); tick();
    chk("rst2.full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2.valid", 32'(out_valid), 32'd0);
    chk("rst2.ready", 32'(in_ready), 32'd1);
    chk("rst2.imm", out_imm, 32'd0);
    chk("rst2.stall", 32'(stall_count), 32'd0);
    out_ready = 1'b1;
    offer(32'h00800093, 32'h31C); tick();
    chk_out("rst2.next", 32'h00800093, 32'd8, 3'b000, 1'b0, 32'h31C);
    in_valid = 1'b0; tick();
    chk("rst2.drain", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
